// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle for the multi-cycle MUL/DIVU/REMU sequencer.
interface alu_muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Sequencer computing MUL/DIVU/REMU one step per clock through the shared execute-stage ALU.
// Optional MULDIV_EARLY_EXIT_EN: MUL finishes as soon as the remaining multiplier bits are zero.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_muldiv_seq_if.slave          bus,
  output logic                     busy,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  input  logic [DATA_WIDTH-1:0]    alu_result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);

  localparam logic [1:0] M_MUL  = 2'b00;
  localparam logic [1:0] M_DIVU = 2'b01;
  localparam logic [1:0] M_REMU = 2'b10;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    acc, mcand, mplier;
  logic [W-1:0]    rem, quo, dvs;
  logic [W-1:0]    rsp_data_q;

  logic            accept, is_mul, last, early, iter_end;
  logic            c, take;
  logic [W-1:0]    t, acc_nxt, mplier_nxt, rem_nxt, quo_nxt, iter_res;
  logic            imm_done;
  logic [W-1:0]    imm_data;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign is_mul = (op_q == M_MUL);

  // Restoring-division step: the bit shifted out of rem forces a subtract.
  assign t        = {rem[W-2:0], quo[W-1]};
  assign c        = rem[W-1];
  assign take     = c || (t >= dvs);
  assign rem_nxt  = take ? alu_result : t;
  assign quo_nxt  = {quo[W-2:0], take};

  assign acc_nxt    = mplier[0] ? alu_result : acc;
  assign mplier_nxt = mplier >> 1;

  assign last = (cnt == CW'(W - 1));
`ifdef MULDIV_EARLY_EXIT_EN
  assign early = is_mul && (mplier_nxt == '0);
`else
  assign early = 1'b0;
`endif
  assign iter_end = last || early;

  always_comb begin
    iter_res = rem_nxt;
    if (is_mul)               iter_res = acc_nxt;
    else if (op_q == M_DIVU)  iter_res = quo_nxt;
  end

  // Requests that resolve without iterating go straight to DONE.
  always_comb begin
    imm_done = 1'b0;
    imm_data = '0;
    case (bus.req_op)
      M_DIVU: if (bus.req_b == '0) begin imm_done = 1'b1; imm_data = '1;        end
      M_REMU: if (bus.req_b == '0) begin imm_done = 1'b1; imm_data = bus.req_a; end
`ifdef MULDIV_EARLY_EXIT_EN
      M_MUL:  if (bus.req_b == '0) begin imm_done = 1'b1; imm_data = '0;        end
`endif
      2'b11:  imm_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_op        = OP_ADD;
    alu_a         = '0;
    alu_b         = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_d = imm_done ? DONE : ITER;
      end
      ITER: begin
        busy   = 1'b1;
        alu_op = is_mul ? OP_ADD : OP_SUB;
        alu_a  = is_mul ? acc    : t;
        alu_b  = is_mul ? mcand  : dvs;
        if (iter_end) state_d = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q <= bus.req_op;
          cnt  <= '0;
          if (bus.req_op == M_MUL) begin
            acc    <= '0;
            mcand  <= bus.req_a;
            mplier <= bus.req_b;
          end else begin
            rem <= '0;
            quo <= bus.req_a;
            dvs <= bus.req_b;
          end
          if (imm_done) rsp_data_q <= imm_data;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_mul) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end
          if (iter_end) rsp_data_q <= iter_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_data = rsp_data_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: arithmetic model + scoreboard compare, plus literal pins.
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busy;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_result;

  alu_muldiv_seq_if #(.DATA_WIDTH(W)) bus();

  alu_muldiv_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  // Shared integer ALU as seen in execute.
  always_comb begin
    alu_result = '0;
    if (alu_op == 4'b0010)      alu_result = alu_a + alu_b;
    else if (alu_op == 4'b0110) alu_result = alu_a - alu_b;
  end

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, nrsp = 0;
  logic [W-1:0] last_rsp = '0;
  bit first_seen = 0;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           acc_cyc;
    logic [1:0]   op;
  } exp_t;
  exp_t q[$];

  function automatic logic [W-1:0] model_res(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a * b;
      2'b01:   return (b == 0) ? '1 : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Cycles from the acceptance cycle to the first cycle rsp_valid is seen.
  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] b);
    int l;
    l = W + 1;
    if (op == 2'b11 || (op != 2'b00 && b == 0)) l = 1;
`ifdef MULDIV_EARLY_EXIT_EN
    if (op == 2'b00) begin
      l = 1;
      for (int i = 0; i < W; i++) if (b[i]) l = i + 2;
    end
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      first_seen = 0;
    end else begin
      chk("req_ready_vs_busy", 32'(bus.req_ready), 32'(!busy));
      if (!busy || bus.rsp_valid) begin
        chk("idle_alu_op", 32'(alu_op), 32'h2);
        chk("idle_alu_a", alu_a, '0);
        chk("idle_alu_b", alu_b, '0);
      end else if (q.size() > 0) begin
        chk("iter_alu_op", 32'(alu_op), (q[0].op == 2'b00) ? 32'h2 : 32'h6);
      end
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("rsp_data", bus.rsp_data, q[0].data);
          if (!first_seen) begin
            first_seen = 1;
            chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
          end
          if (bus.rsp_ready) begin
            last_rsp = bus.rsp_data;
            nrsp++;
            void'(q.pop_front());
          end
        end
        if (bus.rsp_ready) first_seen = 0;
      end
      if (bus.req_valid && bus.req_ready)
        q.push_back('{model_res(bus.req_op, bus.req_a, bus.req_b),
                      model_lat(bus.req_op, bus.req_b), cyc, bus.req_op});
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no req_ready expected acceptance");
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int want);
    int n;
    n = 0;
    while (nrsp < want && n < 200) begin n++; @(negedge clk); end
    if (nrsp < want) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", nrsp, want);
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] lit);
    int want;
    want = nrsp + 1;
    send(op, a, b);
    wait_rsp(want);
    chk(name, last_rsp, lit);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_data"},  bus.rsp_data, '0);
    chk({tag, "_busy"},      32'(busy), 32'h0);
    chk({tag, "_alu_op"},    32'(alu_op), 32'h2);
    chk({tag, "_alu_a"},     alu_a, '0);
    chk({tag, "_alu_b"},     alu_b, '0);
  endtask

  initial begin
    int n;
    logic [W-1:0] held;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 reset = 1'b0;

    run("mul_7x6",        2'b00, 32'd7,          32'd6,          32'd42);
    run("mul_wrap",       2'b00, 32'hFFFF_FFFF,  32'h2,          32'hFFFF_FFFE);
    run("mul_msb_x2",     2'b00, 32'h8000_0000,  32'h2,          32'h0);
    run("mul_by_zero",    2'b00, 32'h1234_5678,  32'h0,          32'h0);
    run("divu_100_7",     2'b01, 32'd100,        32'd7,          32'd14);
    run("remu_100_7",     2'b10, 32'd100,        32'd7,          32'd2);
    run("divu_max_1",     2'b01, 32'hFFFF_FFFF,  32'h1,          32'hFFFF_FFFF);
    run("divu_small_big", 2'b01, 32'd7,          32'd100,        32'd0);
    run("divu_carry",     2'b01, 32'hDEAD_BEEF,  32'h8000_0001,  32'h1);
    run("remu_carry",     2'b10, 32'hDEAD_BEEF,  32'h8000_0001,  32'h5EAD_BEEE);
    run("divu_by_zero",   2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF);
    run("remu_by_zero",   2'b10, 32'd5,          32'd0,          32'd5);
    run("reserved_op",    2'b11, 32'd9,          32'd9,          32'd0);

    // Back-pressure: result held while a second request waits.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    send(2'b00, 32'd9, 32'd9);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin n++; @(negedge clk); end
    if (!bus.rsp_valid) begin
      checks++; errors++;
      $display("FAIL bp_rsp_timeout: got no rsp_valid expected rsp_valid");
    end
    held = bus.rsp_data;
    chk("bp_data_81", held, 32'd81);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd100; bus.req_b = 32'd7;
    repeat (10) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("bp_rsp_stable", bus.rsp_data, held);
      chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1 bus.req_valid = 1'b0;
    wait_rsp(nrsp + 1);
    chk("bp_second_divu", last_rsp, 32'd14);

    // Reset in the middle of a division discards it.
    send(2'b01, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    run("mul_after_reset", 2'b00, 32'd3, 32'd5, 32'd15);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
